// File: rtl/divisor_seq.sv
// divisor_seq -- multicycle signed 32-bit divider (restoring, one bit/cycle).
//
// Produces quotient on lo and remainder on hi with MIPS div semantics:
// the quotient truncates toward zero and the remainder takes the dividend's sign.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   a         in   [31:0] dividend, two's complement
//   b         in   [31:0] divisor, two's complement
//   start     in   operation request, honoured only while idle
//   hi        out  [31:0] remainder (registered)
//   lo        out  [31:0] quotient (registered)
//   div_zero  out  divisor was zero on the last accepted start (sticky)
//   done      out  one-cycle completion pulse
//   busy      out  high while an operation is in flight
module divisor_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero,
  output logic        done,
  output logic        busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   bmag_q, bmag_d;
  logic                sgnq_q, sgnq_d;
  logic                sgnr_q, sgnr_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                dz_q, dz_d;
  logic                done_q, done_d;
  logic [DATA_W:0]     trial;

  // Magnitude as unsigned; the most negative value maps onto itself, which is
  // exactly 2^31 when read back as unsigned.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return v[DATA_W-1] ? n : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic neg,
                                                   input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return neg ? n : v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    trial   = {rem_q, quo_q[DATA_W-1]};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b == '0) begin
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            dz_d    = 1'b0;
            sgnq_d  = a[DATA_W-1] ^ b[DATA_W-1];
            sgnr_d  = a[DATA_W-1];
            bmag_d  = mag(a == a ? b : b);
            quo_d   = mag(a);
            rem_d   = '0;
            cnt_d   = 5'd31;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // The partial remainder is always below |b| <= 2^31 after each step, so
        // only the shifted-in trial value needs the extra bit.
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
        if (trial >= {1'b0, bmag_q}) begin
          rem_d    = trial[DATA_W-1:0] - bmag_q;
          quo_d[0] = 1'b1;
        end else begin
          rem_d = trial[DATA_W-1:0];
        end
        if (cnt_q == 5'd0) state_d = S_FINISH;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_FINISH: begin
        lo_d    = apply_sign(sgnq_q, quo_q);
        hi_d    = apply_sign(sgnr_q, rem_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_divisor_seq.sv
module tb_divisor_seq;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  divisor_seq dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .start    (start),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation; optionally pulse start again (with a=1,b=1) at cycle
  // 'interfere_at' of the run. Returns cycles from accepting edge to done and
  // the number of post-edge samples with busy high (including the one after E0).
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                         input int interfere_at, output int lat, output int busy_cnt);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (lat < 40 && !done) begin
      @(negedge clk);
      if (lat == interfere_at) begin
        start = 1'b1; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int bcnt;
    int done_seen;

    vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 33};
    vecs[4]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 33};
    // divide by zero: hi/lo keep 1/3 from the previous entry, no busy
    vecs[5]  = '{32'd5,        32'd0,        32'd3,        32'd1,        1'b1, 0};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[7]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 33};
    vecs[8]  = '{32'd0,        32'd9,        32'd0,        32'd0,        1'b0, 33};
    vecs[9]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
    vecs[10] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 33};
    vecs[11] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 33};
    vecs[12] = '{32'd1000000,  32'd37,       32'd27027,    32'd1,        1'b0, 33};

    a = '0; b = '0; start = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_dz", {31'd0, div_zero}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_div(vecs[i].a, vecs[i].b, -1, lat, bcnt);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_lat);
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_dz", i), {31'd0, div_zero}, {31'd0, vecs[i].exp_dz});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_fall", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_dz_hold", i), {31'd0, div_zero}, {31'd0, vecs[i].exp_dz});
    end

    // Div-by-zero flag must clear right at the next accepting edge.
    run_div(32'd5, 32'd0, -1, lat, bcnt);
    chk("dz_set", {31'd0, div_zero}, 32'd1);
    @(negedge clk);
    a = 32'd9; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dz_clear_at_accept", {31'd0, div_zero}, 32'd0);
    chk("dz_clear_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    while (lat < 40 && !done) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("dz_follow_latency", lat, 33);
    chk("dz_follow_lo", lo, 32'd2);
    chk("dz_follow_hi", hi, 32'd1);

    // A second start during RUN is ignored.
    run_div(32'd100, 32'd7, 5, lat, bcnt);
    chk("ignore_latency", lat, 33);
    chk("ignore_lo", lo, 32'd14);
    chk("ignore_hi", hi, 32'd2);
    @(posedge clk); #1;
    chk("ignore_no_restart", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN aborts immediately.
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_dz", {31'd0, div_zero}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    run_div(32'd9, 32'd3, -1, lat, bcnt);
    chk("post_reset_latency", lat, 33);
    chk("post_reset_lo", lo, 32'd3);
    chk("post_reset_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
